// File: rtl/afu_write_ctrl_if.sv
// rtl/afu_write_ctrl_if.sv - output-FIFO read port and host write channel of the transpose AFU write stage
interface afu_write_ctrl_if #(
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 32
);
  logic [LINE_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_re;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LINE_WIDTH-1:0] wr_data;
  logic                  wr_rsp_valid;

  modport master (
    input  fifo_dout, fifo_empty, wr_ready, wr_rsp_valid,
    output fifo_re, wr_valid, wr_addr, wr_data
  );

  modport slave (
    output fifo_dout, fifo_empty, wr_ready, wr_rsp_valid,
    input  fifo_re, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/afu_write_ctrl.sv
// rtl/afu_write_ctrl.sv - drains transposed lines from the output FIFO into bounded-outstanding host writes
// Optional running write checksum output when WRITE_CHECKSUM_EN is defined.
module afu_write_ctrl #(
  parameter int LINE_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] ctx_base_addr_i,
  input  logic [31:0]           ctx_length_i,
  afu_write_ctrl_if.master      bus,
  output logic                  busy_o,
  output logic                  done_o
`ifdef WRITE_CHECKSUM_EN
  ,
  output logic [31:0]           checksum_o
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           read_cnt_q, read_cnt_d;
  logic [31:0]           written_cnt_q, written_cnt_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  head_q, head_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pend_q, pend_d;
  logic [LINE_WIDTH-1:0] buf_q [2];

  logic       wr_valid_w;
  logic       fire;
  logic       fifo_re_w;
  logic       accept_start;
  logic [2:0] level;
  logic       tail;

  // wr_valid depends only on registers, so it can never combinationally follow wr_ready.
  assign wr_valid_w   = (occ_q != 2'd0) && (outst_q < OW'(MAX_OUTSTANDING));
  assign fire         = wr_valid_w & bus.wr_ready;
  assign level        = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, fire};
  assign fifo_re_w    = (state_q == S_RUN) & ~bus.fifo_empty & (read_cnt_q < len_q) & (level < 3'd2);
  assign accept_start = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign tail         = head_q ^ occ_q[0];

  assign bus.fifo_re  = fifo_re_w;
  assign bus.wr_valid = wr_valid_w;
  assign bus.wr_addr  = wr_valid_w ? (base_q + ADDR_WIDTH'(written_cnt_q)) : '0;
  assign bus.wr_data  = wr_valid_w ? buf_q[head_q] : '0;
  assign busy_o       = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    read_cnt_d    = read_cnt_q;
    written_cnt_d = written_cnt_q;
    head_d        = head_q;
    occ_d         = level[1:0];
    pend_d        = fifo_re_w;
    outst_d       = outst_q;

    if (fifo_re_w) read_cnt_d = read_cnt_q + 32'd1;
    if (fire) begin
      written_cnt_d = written_cnt_q + 32'd1;
      head_d        = ~head_q;
    end

    // A response and a fire in the same cycle cancel; stray responses at zero are dropped.
    case ({fire, bus.wr_rsp_valid})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   if (outst_q != '0) outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_start) begin
          base_d        = ctx_base_addr_i;
          len_d         = ctx_length_i;
          read_cnt_d    = '0;
          written_cnt_d = '0;
          head_d        = 1'b0;
          occ_d         = 2'd0;
          pend_d        = 1'b0;
          state_d       = (ctx_length_i == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (written_cnt_q == len_q) state_d = S_DRAIN;
      S_DRAIN: if (outst_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      read_cnt_q    <= '0;
      written_cnt_q <= '0;
      outst_q       <= '0;
      head_q        <= 1'b0;
      occ_q         <= 2'd0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      read_cnt_q    <= read_cnt_d;
      written_cnt_q <= written_cnt_d;
      outst_q       <= outst_d;
      head_q        <= head_d;
      occ_q         <= occ_d;
      pend_q        <= pend_d;
    end
  end

  // FIFO data lands one cycle after its read; the slot after the live entries is always free.
  always_ff @(posedge clk_i) begin
    if (pend_q) buf_q[tail] <= bus.fifo_dout;
  end

`ifdef WRITE_CHECKSUM_EN
  function automatic logic [31:0] xor_fold(input logic [LINE_WIDTH-1:0] d);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < LINE_WIDTH / 32; i++) acc ^= d[i*32 +: 32];
    return acc;
  endfunction

  logic [31:0] checksum_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)         checksum_q <= '0;
    else if (accept_start) checksum_q <= '0;
    else if (fire)         checksum_q <= checksum_q + xor_fold(bus.wr_data);
  end

  assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_afu_write_ctrl.sv
// tb/tb_afu_write_ctrl.sv - randomized scoreboard bench for afu_write_ctrl
module tb_afu_write_ctrl;
  localparam int LW = 512;
  localparam int AW = 32;
  localparam int MO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_in;
  logic [31:0]   len_in;
  logic          busy, done;
`ifdef WRITE_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  afu_write_ctrl_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus();

  afu_write_ctrl #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start),
    .ctx_base_addr_i(base_in), .ctx_length_i(len_in),
    .bus(bus.master), .busy_o(busy), .done_o(done)
`ifdef WRITE_CHECKSUM_EN
    , .checksum_o(checksum)
`endif
  );

  int checks, errors;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [LW-1:0] fifo_q[$];
  logic [LW-1:0] exp_q[$];
  int            rsp_due[$];
  int            fire_cyc[$];
  logic [AW-1:0] fire_addr[$];
  int            reads, fires, rsps, out_m, cyc, re_count, start_cyc;
  logic [AW-1:0] m_base;
  logic [31:0]   m_len;
  bit            pend_re;
  logic [LW-1:0] pend_line;
  bit            rsp_en;
  int            rsp_delay, ready_pct, stall_pct, feed_left;
  bit            prev_stall, job_active, last_done, start_req;
  logic [AW-1:0] prev_addr;
  logic [LW-1:0] prev_data;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic push_line(input logic [LW-1:0] l);
    fifo_q.push_back(l);
    exp_q.push_back(l);
  endtask

  // One clock: drive at the falling edge, sample 1ns later, update the scoreboard.
  task automatic step();
    bit            fire_s, rsp_s, re_s;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    if (pend_re) begin
      bus.fifo_dout = pend_line;
      pend_re = 1'b0;
    end
    if (feed_left > 0 && $urandom_range(99) < 50) begin
      push_line(rand_line());
      feed_left--;
    end
    start          = start_req;
    bus.wr_ready   = ($urandom_range(99) < ready_pct);
    bus.fifo_empty = (fifo_q.size() == 0) || ($urandom_range(99) < stall_pct);
    rsp_s = 1'b0;
    if (rsp_en && rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
      void'(rsp_due.pop_front());
      rsp_s = 1'b1;
    end
    bus.wr_rsp_valid = rsp_s;
    #1;
    re_s   = bus.fifo_re;
    fire_s = bus.wr_valid & bus.wr_ready;
    if (prev_stall) begin
      chk("hold_valid", bus.wr_valid, 1'b1);
      chk("hold_addr", bus.wr_addr, prev_addr);
      chk("hold_data", bus.wr_data, prev_data);
    end
    if (!rst_n) begin
      chk("re_in_reset", re_s, 1'b0);
      chk("valid_in_reset", bus.wr_valid, 1'b0);
    end
    if (job_active) begin
      chk("busy_vs_done", busy, !done);
      if (done) chk("done_early", (fires == m_len) && (out_m == 0), 1'b1);
    end
    if (bus.wr_valid) chk("outstanding_limit", out_m < MO, 1'b1);
    if (re_s) begin
      chk("re_when_empty", bus.fifo_empty, 1'b0);
      chk("re_beyond_len", reads < m_len, 1'b1);
      if (fifo_q.size() > 0) pend_line = fifo_q.pop_front();
      pend_re = 1'b1;
      reads++;
      re_count++;
    end
    if (fire_s) begin
      exp_addr = m_base + AW'(fires);
      chk("wr_addr", bus.wr_addr, exp_addr);
      if (fires < exp_q.size()) chk("wr_data", bus.wr_data, exp_q[fires]);
      else chk("write_count", fires, exp_q.size());
      chk("write_beyond_len", fires < m_len, 1'b1);
      fire_cyc.push_back(cyc);
      fire_addr.push_back(bus.wr_addr);
      fires++;
      out_m++;
      rsp_due.push_back(cyc + ((rsp_delay < 0) ? int'($urandom_range(8, 1)) : rsp_delay));
    end
    if (rsp_s) begin
      rsps++;
      if (out_m > 0) out_m--;
    end
    chk("in_flight", (reads - fires) <= 2, 1'b1);
    prev_stall = bus.wr_valid & ~bus.wr_ready;
    prev_addr  = bus.wr_addr;
    prev_data  = bus.wr_data;
    last_done  = done;
    cyc++;
  endtask

  task automatic new_job(input logic [AW-1:0] b, input logic [31:0] l);
    fifo_q.delete();
    exp_q.delete();
    fire_cyc.delete();
    fire_addr.delete();
    reads = 0; fires = 0; rsps = 0; re_count = 0; feed_left = 0;
    m_base = b; m_len = l;
    base_in = b; len_in = l;
  endtask

  task automatic start_job();
    start_req  = 1'b1;
    job_active = 1'b0;
    start_cyc  = cyc;
    step();
    start_req  = 1'b0;
    job_active = 1'b1;
  endtask

  task automatic run_until_done(input int limit);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_done && n < limit);
    chk("done_reached", last_done, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_fifo_re"}, bus.fifo_re, 1'b0);
    chk({tag, "_wr_valid"}, bus.wr_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_wr_addr"}, bus.wr_addr, '0);
    chk({tag, "_wr_data"}, bus.wr_data, '0);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0; out_m = 0;
    rst_n = 1'b0; start = 1'b0; start_req = 1'b0; base_in = '0; len_in = '0;
    bus.fifo_dout = '0; bus.fifo_empty = 1'b1; bus.wr_ready = 1'b0; bus.wr_rsp_valid = 1'b0;
    pend_re = 1'b0; prev_stall = 1'b0; job_active = 1'b0; last_done = 1'b0;
    rsp_en = 1'b1; rsp_delay = 3; ready_pct = 100; stall_pct = 0;
    new_job('0, '0);
    repeat (3) step();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // Preloaded 4-line job with fixed 3-cycle response latency.
    new_job(32'h100, 4);
    for (int i = 0; i < 4; i++) push_line(rand_line());
    start_job();
    run_until_done(100);
    chk("t1_fires", fires, 4);
    chk("t1_fifo_re_pulses", re_count, 4);
    chk("t1_rsps", rsps, 4);
    if (fire_cyc.size() == 4) begin
      chk("t1_first_fire_latency", fire_cyc[0], start_cyc + 3);
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", fire_addr[i], 32'h100 + i);
        chk("t1_back_to_back", fire_cyc[i], fire_cyc[0] + i);
      end
    end

    // Zero-length job completes at once without touching FIFO or write channel.
    new_job(32'h55, 0);
    push_line(rand_line());
    push_line(rand_line());
    start_job();
    step();
    chk("t2_done_next_cycle", last_done, 1'b1);
    repeat (5) step();
    chk("t2_no_reads", re_count, 0);
    chk("t2_no_writes", fires, 0);

    // Outstanding limit: responses withheld until 16 writes are in flight.
    new_job(32'h3000, 20);
    for (int i = 0; i < 20; i++) push_line(rand_line());
    rsp_en = 1'b0; rsp_delay = 1;
    start_job();
    repeat (40) step();
    chk("t3_fires_at_limit", fires, 16);
    chk("t3_valid_blocked", bus.wr_valid, 1'b0);
    rsp_en = 1'b1;
    step();
    chk("t3_no_fire_in_rsp_cycle", fires, 16);
    step();
    chk("t3_resumed", fires, 17);
    run_until_done(200);
    chk("t3_fires", fires, 20);
    chk("t3_rsps", rsps, 20);

    // Random backpressure, bursty FIFO and random response latency, base near address wrap.
    new_job(32'hFFFF_FFE0 + $urandom_range(15), 64);
    feed_left = 64; ready_pct = 60; stall_pct = 30; rsp_delay = -1;
    start_job();
    run_until_done(5000);
    chk("t4_fires", fires, 64);
    chk("t4_reads", re_count, 64);
    chk("t4_rsps", rsps, 64);

    // Asynchronous reset mid-job, then a fresh short job.
    new_job(32'h200, 10);
    for (int i = 0; i < 10; i++) push_line(rand_line());
    ready_pct = 100; stall_pct = 0; rsp_delay = 20;
    start_job();
    n = 0;
    while (fires < 5 && n < 100) begin
      step();
      n++;
    end
    chk("t5_fires_before_reset", fires, 5);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t5_async");
    rsp_due.delete();
    out_m = 0; pend_re = 1'b0; prev_stall = 1'b0; job_active = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    new_job(32'h0, 2);
    push_line(rand_line());
    push_line(rand_line());
    rsp_delay = 3;
    start_job();
    run_until_done(100);
    chk("t5_fires", fires, 2);
    if (fire_addr.size() == 2) begin
      chk("t5_addr0", fire_addr[0], 32'h0);
      chk("t5_addr1", fire_addr[1], 32'h1);
    end

`ifdef WRITE_CHECKSUM_EN
    new_job(32'h10, 2);
    push_line({LW{1'b1}});
    push_line({{(LW-1){1'b0}}, 1'b1});
    start_job();
    run_until_done(100);
    chk("t6_checksum", checksum, 32'h0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/afu_write_ctrl.md
Name: afu_write_ctrl

Overview:
- Downstream stage of the transpose AFU user block.
- Drains 512-bit transposed lines from the synchronous-read output FIFO.
- Issues one cache-line write request per line to the host write channel, with a bounded number of outstanding writes.
- Signals completion once ctx_length lines are written and all write responses have returned.

Parameters:
- LINE_WIDTH, 512, data bits per line/write request.
- ADDR_WIDTH, 32, cache-line address width (64-byte units).
- MAX_OUTSTANDING, 16, maximum writes issued but not yet acknowledged (power of 2, ≥2).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches ctx_base_addr and ctx_length
- ctx_base_addr  input  ADDR_WIDTH  cache-line address of line 0
- ctx_length  input  32  number of lines to write
- fifo_dout  input  LINE_WIDTH  output-FIFO read data, valid the cycle after fifo_re
- fifo_empty  input  1  output-FIFO empty
- fifo_re  output  1  output-FIFO read enable
- wr_valid  output  1  write request valid
- wr_ready  input  1  write channel accepts request
- wr_addr  output  ADDR_WIDTH  request cache-line address
- wr_data  output  LINE_WIDTH  request data
- wr_rsp_valid  input  1  one write acknowledged (one pulse per write)
- busy  output  1  high in RUN or DRAIN
- done  output  1  high in DONE

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; all counters 0; 2-entry buffer empty.
  - fifo_re=0, wr_valid=0, busy=0, done=0; wr_addr/wr_data=0.
  - Reset mid-operation abandons the job; no further fifo_re or wr_valid until the next start.
- FSM states:
  - IDLE: start with ctx_length=0 -> DONE; start otherwise -> RUN.
  - RUN: when written_cnt==ctx_length -> DRAIN.
  - DRAIN: when outstanding==0 -> DONE.
  - DONE: done held high; start restarts with the same rules as IDLE.
  - start in RUN/DRAIN is ignored.
- Read side:
  - Combinational fifo_re = RUN & ~fifo_empty & (read_cnt<ctx_length) & (occ + pend - pop < 2).
    - occ: buffer occupancy.
    - pend: 1 if fifo_re was asserted last cycle.
    - pop: write fired this cycle.
  - read_cnt increments per fifo_re.
  - fifo_dout is captured into the buffer the cycle after fifo_re.
  - Sustains 1 line/cycle when wr_ready is held high.
- Write side:
  - wr_valid = buffer nonempty & (outstanding < MAX_OUTSTANDING).
  - wr_data is the buffer head; wr_addr = latched base + written_cnt, wrapping modulo 2^ADDR_WIDTH.
  - Fire = wr_valid & wr_ready; advances the head and increments written_cnt.
  - Once asserted, wr_valid, wr_addr and wr_data hold stable until fire.
  - wr_valid is also registered-independent of wr_ready (no combinational ready->valid path).
- Outstanding counter:
  - +1 on fire, −1 on wr_rsp_valid, unchanged when both occur in the same cycle.
  - wr_rsp_valid with outstanding==0 is ignored; the counter saturates at 0.
- Order: lines are written strictly in FIFO order. Latency from fifo_re to first possible wr_valid is 2 cycles.
- Counters are 32-bit; ctx_length up to 2^32−1 is supported.

Optional Feature:
- Macro WRITE_CHECKSUM_EN.
- When defined:
  - Adds output checksum (32 bits).
  - On every fire: checksum <= checksum + XOR-fold of wr_data into 32 bits (the 16 words of 32 bits XORed together), modulo 2^32.
  - Cleared on reset and on any accepted start; stable and valid while done=1.
- When undefined: no port, no logic.

Test Plan:
- ctx_length=4, base=0x100, FIFO preloaded 4 lines, wr_ready=1, responses 3 cycles after each fire -> wr_addr 0x100..0x103 in order, data matches FIFO, back-to-back fires, done=1 after the 4th response, exactly 4 fifo_re pulses.
- ctx_length=0 start -> done=1 the next cycle, fifo_re and wr_valid never asserted.
- MAX_OUTSTANDING=16, ctx_length=20, no responses until the 16th fire -> wr_valid drops after 16 fires; resumes after the first wr_rsp_valid; done only after 20 responses.
- wr_ready toggled randomly, fifo_empty bursty, ctx_length=64 -> no dropped/duplicated line, wr_addr/wr_data stable while wr_valid & ~wr_ready, buffer never overflows (occ ≤ 2).
- reset pulled low after 5 of 10 writes -> all outputs 0 immediately; a new start with ctx_length=2, base=0x0 -> addresses 0x0, 0x1 only.
- WRITE_CHECKSUM_EN: 2 lines, all-ones and 0x…0001 (only bit 0 set) -> checksum = 0x00000000 + 0x00000001 = 0x00000001 at done.
